// File: rtl/imm_gen_unit.sv
// Registered RV32I immediate generator: classifies the opcode and emits the sign-extended immediate one cycle later.
// Optional macro IMM_SHAMT_MASK_EN zero-extends the 5-bit shift amount for SLLI/SRLI/SRAI.
module imm_gen_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] inst,
  input  logic            in_valid,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            imm_valid
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;

  function automatic logic [2:0] classify(input logic [6:0] opcode);
    case (opcode)
      7'b0000011, 7'b0010011, 7'b1100111,
      7'b0001111, 7'b1110011:             classify = FMT_I;
      7'b0100011:                         classify = FMT_S;
      7'b1100011:                         classify = FMT_B;
      7'b0110111, 7'b0010111:             classify = FMT_U;
      7'b1101111:                         classify = FMT_J;
      default:                            classify = FMT_NONE;
    endcase
  endfunction

  function automatic logic signed [XLEN-1:0] assemble(input logic [XLEN-1:0] ins,
                                                      input logic [2:0]      f);
    case (f)
      FMT_I:   assemble = {{(XLEN-12){ins[31]}}, ins[31:20]};
      FMT_S:   assemble = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
      FMT_B:   assemble = {{(XLEN-13){ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      FMT_U:   assemble = {ins[31:12], 12'b0};
      FMT_J:   assemble = {{(XLEN-21){ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: assemble = '0;
    endcase
  endfunction

  logic [2:0]             fmt_dec;
  logic signed [XLEN-1:0] imm_dec;
  logic [2:0]             fmt_d, fmt_q;
  logic signed [XLEN-1:0] imm_d, imm_q;
  logic                   vld_d, vld_q;

  always_comb begin
    fmt_dec = classify(inst[6:0]);
    imm_dec = assemble(inst, fmt_dec);
`ifdef IMM_SHAMT_MASK_EN
    // Shift-immediates carry only a 5-bit shamt; drop the SRAI funct7 marker.
    if (inst[6:0] == 7'b0010011 && inst[13:12] == 2'b01)
      imm_dec = {{(XLEN-5){1'b0}}, inst[24:20]};
`endif
  end

  always_comb begin
    fmt_d = fmt_q;
    imm_d = imm_q;
    vld_d = in_valid;
    if (in_valid) begin
      fmt_d = fmt_dec;
      imm_d = imm_dec;
    end
  end

  // Stage boundary: decode -> registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      fmt_q <= FMT_NONE;
      imm_q <= '0;
      vld_q <= 1'b0;
    end else begin
      fmt_q <= fmt_d;
      imm_q <= imm_d;
      vld_q <= vld_d;
    end
  end

  assign imm       = imm_q;
  assign fmt       = fmt_q;
  assign imm_valid = vld_q;

endmodule

// File: tb/tb_imm_gen_unit.sv
// Self-checking bench for imm_gen_unit: directed vectors plus a randomized stream against a behavioural model.
module tb_imm_gen_unit;

  logic        clk;
  logic        rst;
  logic [31:0] inst;
  logic        in_valid;
  logic [31:0] imm;
  logic [2:0]  fmt;
  logic        imm_valid;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] exp_imm;
  logic [2:0]  exp_fmt;
  logic        exp_vld;

  imm_gen_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .inst(inst), .in_valid(in_valid),
    .imm(imm), .fmt(fmt), .imm_valid(imm_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] ref_fmt(input logic [31:0] i);
    case (i[6:0])
      7'h03, 7'h13, 7'h67, 7'h0F, 7'h73: ref_fmt = 3'd1;
      7'h23: ref_fmt = 3'd2;
      7'h63: ref_fmt = 3'd3;
      7'h37, 7'h17: ref_fmt = 3'd4;
      7'h6F: ref_fmt = 3'd5;
      default: ref_fmt = 3'd0;
    endcase
  endfunction

  // Field extraction by shifts and masks on the whole word.
  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    logic [31:0] sgn;
    sgn = (i[31]) ? 32'hFFFF_FFFF : 32'h0;
    case (ref_fmt(i))
      3'd1: begin
        ref_imm = (sgn << 12) | ((i >> 20) & 32'hFFF);
`ifdef IMM_SHAMT_MASK_EN
        if (i[6:0] == 7'h13 && (((i >> 12) & 7) == 1 || ((i >> 12) & 7) == 5))
          ref_imm = (i >> 20) & 32'h1F;
`endif
      end
      3'd2: ref_imm = (sgn << 12) | (((i >> 25) & 32'h7F) << 5) | ((i >> 7) & 32'h1F);
      3'd3: ref_imm = (sgn << 12) | (((i >> 7) & 1) << 11) | (((i >> 25) & 32'h3F) << 5)
                      | (((i >> 8) & 32'hF) << 1);
      3'd4: ref_imm = i & 32'hFFFF_F000;
      3'd5: ref_imm = (sgn << 20) | (i & 32'h000F_F000) | (((i >> 20) & 1) << 11)
                      | (((i >> 21) & 32'h3FF) << 1);
      default: ref_imm = 32'h0;
    endcase
  endfunction

  // Drive one cycle, advance past the edge and update the expected outputs.
  task automatic cycle(input logic r, input logic v, input logic [31:0] ins);
    rst = r; in_valid = v; inst = ins;
    @(posedge clk);
    #1;
    if (r) begin
      exp_imm = 32'h0; exp_fmt = 3'd0; exp_vld = 1'b0;
    end else if (v) begin
      exp_imm = ref_imm(ins); exp_fmt = ref_fmt(ins); exp_vld = 1'b1;
    end else begin
      exp_vld = 1'b0;
    end
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b1, 32'hFFC12083);
    cycle(1'b1, 1'b1, 32'hFFC12083);
    tests_run++;
    if ({imm, fmt, imm_valid} !== {32'h0, 3'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset: got imm=%h fmt=%0d vld=%b want 00000000/0/0", imm, fmt, imm_valid);
    end
    cycle(1'b0, 1'b1, 32'hFFC12083);
    tests_run++;
    if ({imm, fmt, imm_valid} !== {32'hFFFF_FFFC, 3'd1, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_release: got imm=%h fmt=%0d vld=%b want fffffffc/1/1", imm, fmt, imm_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins [4] = '{32'h00512423, 32'hFE000CE3, 32'h123450B7, 32'h001000EF};
    logic [31:0] want_imm [4] = '{32'h8, 32'hFFFF_FFF8, 32'h1234_5000, 32'h800};
    logic [2:0]  want_fmt [4] = '{3'd2, 3'd3, 3'd4, 3'd5};
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b1, ins[k]);
      tests_run++;
      if ({imm, fmt, imm_valid} !== {want_imm[k], want_fmt[k], 1'b1}) begin
        tests_failed++;
        $display("FAIL b2b[%0d]: got imm=%h fmt=%0d vld=%b want %h/%0d/1",
                 k, imm, fmt, imm_valid, want_imm[k], want_fmt[k]);
      end
    end
  endtask

  task automatic test_hold();
    cycle(1'b0, 1'b0, 32'hFFFF_FFFF);
    cycle(1'b0, 1'b0, 32'h1234_5678);
    tests_run++;
    if ({imm, fmt, imm_valid} !== {32'h800, 3'd5, 1'b0}) begin
      tests_failed++;
      $display("FAIL hold: got imm=%h fmt=%0d vld=%b want 00000800/5/0", imm, fmt, imm_valid);
    end
  endtask

  task automatic test_none_fmt();
    logic [31:0] ins [2] = '{32'h002081B3, 32'h0000000B};
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0, 1'b1, ins[k]);
      tests_run++;
      if ({imm, fmt, imm_valid} !== {32'h0, 3'd0, 1'b1}) begin
        tests_failed++;
        $display("FAIL none_fmt[%0d]: got imm=%h fmt=%0d vld=%b want 00000000/0/1",
                 k, imm, fmt, imm_valid);
      end
    end
  endtask

  task automatic test_srai();
    logic [31:0] want;
`ifdef IMM_SHAMT_MASK_EN
    want = 32'h3;
`else
    want = 32'h403;
`endif
    cycle(1'b0, 1'b1, 32'h4030D093);
    tests_run++;
    if ({imm, fmt, imm_valid} !== {want, 3'd1, 1'b1}) begin
      tests_failed++;
      $display("FAIL srai: got imm=%h fmt=%0d vld=%b want %h/1/1", imm, fmt, imm_valid, want);
    end
  endtask

  task automatic test_mid_reset();
    cycle(1'b0, 1'b1, 32'h001000EF);
    cycle(1'b1, 1'b1, 32'h00512423);
    tests_run++;
    if ({imm, fmt, imm_valid} !== {32'h0, 3'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL mid_reset: got imm=%h fmt=%0d vld=%b want 00000000/0/0", imm, fmt, imm_valid);
    end
    cycle(1'b0, 1'b1, 32'hFE000CE3);
    tests_run++;
    if ({imm, fmt, imm_valid} !== {32'hFFFF_FFF8, 3'd3, 1'b1}) begin
      tests_failed++;
      $display("FAIL mid_reset_resume: got imm=%h fmt=%0d vld=%b want fffffff8/3/1", imm, fmt, imm_valid);
    end
  endtask

  task automatic test_random();
    logic [6:0]  ops [16] = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h37,
                              7'h17, 7'h6F, 7'h33, 7'h0B, 7'h7F, 7'h00, 7'h13, 7'h63};
    logic [31:0] r;
    logic        v, rr;
    for (int n = 0; n < 400; n++) begin
      r  = $urandom;
      r[6:0] = ops[$urandom_range(0, 15)];
      v  = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 49) == 0);
      cycle(rr, v, r);
      tests_run++;
      if ({imm, fmt, imm_valid} !== {exp_imm, exp_fmt, exp_vld}) begin
        tests_failed++;
        $display("FAIL random[%0d] inst=%h: got imm=%h fmt=%0d vld=%b want %h/%0d/%b",
                 n, r, imm, fmt, imm_valid, exp_imm, exp_fmt, exp_vld);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; inst = 32'h0;
    exp_imm = 32'h0; exp_fmt = 3'd0; exp_vld = 1'b0;
    test_reset();
    test_back_to_back();
    test_hold();
    test_none_fmt();
    test_srai();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
